// File: rtl/zap_wb_merger.sv
// Two-master Wishbone merger for the cache fill/writeback FSM and the TLB walk FSM.
// Ownership is held for the whole cyc assertion; the winner's next-cycle signals are registered onto the bus.
module zap_wb_merger #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_c_wb_cyc_nxt,
    input  logic        i_c_wb_stb_nxt,
    input  logic [31:0] i_c_wb_adr_nxt,
    input  logic        i_c_wb_wen_nxt,
    input  logic [3:0]  i_c_wb_sel_nxt,
    input  logic [31:0] i_c_wb_dat_nxt,
    input  logic [2:0]  i_c_wb_cti_nxt,
    input  logic [1:0]  i_c_wb_bte_nxt,
    input  logic        i_t_wb_cyc_nxt,
    input  logic        i_t_wb_stb_nxt,
    input  logic [31:0] i_t_wb_adr_nxt,
    input  logic        i_t_wb_wen_nxt,
    input  logic [3:0]  i_t_wb_sel_nxt,
    input  logic [31:0] i_t_wb_dat_nxt,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    output logic [1:0]  o_wb_bte,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,
    output logic        o_c_wb_ack,
    output logic        o_t_wb_ack,
    output logic [31:0] o_wb_dat_rd
);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_T} state_t;

    state_t      state_q, state_d;
    logic        last_t_q, last_t_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, wen_q, wen_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  cti_q, cti_d;
    logic [1:0]  bte_q, bte_d;
    logic        load_c, load_t;

    always_comb begin
        state_d  = state_q;
        last_t_d = last_t_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        wen_d    = wen_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        cti_d    = cti_q;
        bte_d    = bte_q;
        load_c   = 1'b0;
        load_t   = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the TLB wins unless round-robin says the cache is due.
                if (i_t_wb_cyc_nxt &&
                    (!i_c_wb_cyc_nxt || !ROUND_ROBIN || !last_t_q)) begin
                    load_t   = 1'b1;
                    state_d  = OWN_T;
                    last_t_d = 1'b1;
                end else if (i_c_wb_cyc_nxt) begin
                    load_c   = 1'b1;
                    state_d  = OWN_C;
                    last_t_d = 1'b0;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            end
            OWN_C: begin
                if (i_c_wb_cyc_nxt) begin
                    load_c = 1'b1;
                end else begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end
            end
            OWN_T: begin
                if (i_t_wb_cyc_nxt) begin
                    load_t = 1'b1;
                end else begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (load_c) begin
            cyc_d = i_c_wb_cyc_nxt;
            stb_d = i_c_wb_stb_nxt;
            wen_d = i_c_wb_wen_nxt;
            adr_d = i_c_wb_adr_nxt;
            dat_d = i_c_wb_dat_nxt;
            sel_d = i_c_wb_sel_nxt;
            cti_d = i_c_wb_cti_nxt;
            bte_d = i_c_wb_bte_nxt;
        end else if (load_t) begin
            // Page walks are always single classic cycles.
            cyc_d = i_t_wb_cyc_nxt;
            stb_d = i_t_wb_stb_nxt;
            wen_d = i_t_wb_wen_nxt;
            adr_d = i_t_wb_adr_nxt;
            dat_d = i_t_wb_dat_nxt;
            sel_d = i_t_wb_sel_nxt;
            cti_d = 3'b111;
            bte_d = 2'b00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            last_t_q <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            wen_q    <= 1'b0;
            adr_q    <= 32'd0;
            dat_q    <= 32'd0;
            sel_q    <= 4'd0;
            cti_q    <= 3'd0;
            bte_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            last_t_q <= last_t_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            cti_q    <= cti_d;
            bte_q    <= bte_d;
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_wen    = wen_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_cti    = cti_q;
    assign o_wb_bte    = bte_q;
    assign o_c_wb_ack  = i_wb_ack && (state_q == OWN_C);
    assign o_t_wb_ack  = i_wb_ack && (state_q == OWN_T);
    assign o_wb_dat_rd = i_wb_dat;

endmodule

// File: tb/tb_zap_wb_merger.sv
// Directed bench for zap_wb_merger: a fixed-priority instance and a round-robin instance share stimulus.
module tb_zap_wb_merger;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_cyc, c_stb, c_wen, t_cyc, t_stb, t_wen;
    logic [31:0] c_adr, c_dat, t_adr, t_dat;
    logic [3:0]  c_sel, t_sel;
    logic [2:0]  c_cti;
    logic [1:0]  c_bte;
    logic        ack;
    logic [31:0] rdat;

    logic        cyc, stb, wen, c_ack, t_ack;
    logic [31:0] adr, wdat, dat_rd;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic        r_cyc, r_stb, r_wen, r_c_ack, r_t_ack;
    logic [31:0] r_adr, r_wdat, r_dat_rd;
    logic [3:0]  r_sel;
    logic [2:0]  r_cti;
    logic [1:0]  r_bte;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zap_wb_merger #(.ROUND_ROBIN(1'b0)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_adr_nxt(c_adr),
        .i_c_wb_wen_nxt(c_wen), .i_c_wb_sel_nxt(c_sel), .i_c_wb_dat_nxt(c_dat),
        .i_c_wb_cti_nxt(c_cti), .i_c_wb_bte_nxt(c_bte),
        .i_t_wb_cyc_nxt(t_cyc), .i_t_wb_stb_nxt(t_stb), .i_t_wb_adr_nxt(t_adr),
        .i_t_wb_wen_nxt(t_wen), .i_t_wb_sel_nxt(t_sel), .i_t_wb_dat_nxt(t_dat),
        .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_wen(wen), .o_wb_adr(adr),
        .o_wb_dat(wdat), .o_wb_sel(sel), .o_wb_cti(cti), .o_wb_bte(bte),
        .i_wb_ack(ack), .i_wb_dat(rdat),
        .o_c_wb_ack(c_ack), .o_t_wb_ack(t_ack), .o_wb_dat_rd(dat_rd)
    );

    zap_wb_merger #(.ROUND_ROBIN(1'b1)) dut_rr (
        .i_clk(clk), .i_reset(rst),
        .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_adr_nxt(c_adr),
        .i_c_wb_wen_nxt(c_wen), .i_c_wb_sel_nxt(c_sel), .i_c_wb_dat_nxt(c_dat),
        .i_c_wb_cti_nxt(c_cti), .i_c_wb_bte_nxt(c_bte),
        .i_t_wb_cyc_nxt(t_cyc), .i_t_wb_stb_nxt(t_stb), .i_t_wb_adr_nxt(t_adr),
        .i_t_wb_wen_nxt(t_wen), .i_t_wb_sel_nxt(t_sel), .i_t_wb_dat_nxt(t_dat),
        .o_wb_cyc(r_cyc), .o_wb_stb(r_stb), .o_wb_wen(r_wen), .o_wb_adr(r_adr),
        .o_wb_dat(r_wdat), .o_wb_sel(r_sel), .o_wb_cti(r_cti), .o_wb_bte(r_bte),
        .i_wb_ack(ack), .i_wb_dat(rdat),
        .o_c_wb_ack(r_c_ack), .o_t_wb_ack(r_t_ack), .o_wb_dat_rd(r_dat_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Clock edge, then let registered outputs settle before checking.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input logic cy, input logic st, input logic [31:0] a, input logic [2:0] ct);
        c_cyc = cy; c_stb = st; c_adr = a; c_cti = ct;
    endtask

    task automatic drive_t(input logic cy, input logic [31:0] a);
        t_cyc = cy; t_stb = cy; t_adr = a;
    endtask

    logic [31:0] burst_adr [4];
    logic [2:0]  burst_cti [4];

    initial begin
        burst_adr[0] = 32'h1000; burst_adr[1] = 32'h1004;
        burst_adr[2] = 32'h1008; burst_adr[3] = 32'h100C;
        burst_cti[0] = 3'b010;   burst_cti[1] = 3'b010;
        burst_cti[2] = 3'b010;   burst_cti[3] = 3'b111;

        rst = 1'b1; ack = 1'b1; rdat = 32'hDEAD_BEEF;
        c_wen = 1'b1; c_sel = 4'hF; c_dat = 32'hCAFE_0001; c_bte = 2'b01;
        t_wen = 1'b0; t_sel = 4'hF; t_dat = 32'h0;
        drive_c(1'b1, 1'b1, 32'h0000_2000, 3'b010);
        drive_t(1'b1, 32'h0000_4000);

        // Reset held two cycles with both masters requesting.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_cyc", {31'd0, cyc}, 32'd0);
            check("rst_adr", adr, 32'd0);
            check("rst_cti", {29'd0, cti}, 32'd0);
            check("rst_acks", {30'd0, c_ack, t_ack}, 32'd0);
        end
        check("rd_broadcast", dat_rd, 32'hDEAD_BEEF);
        ack = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_tlb_cyc", {31'd0, cyc}, 32'd1);
        check("post_rst_tlb_adr", adr, 32'h0000_4000);
        check("post_rst_tlb_cti", {29'd0, cti}, 32'd7);
        check("post_rst_rr_tlb_adr", r_adr, 32'h0000_4000);
        drive_c(1'b0, 1'b0, 32'h0, 3'b000);
        drive_t(1'b0, 32'h0);
        step();
        check("release_cyc", {31'd0, cyc}, 32'd0);

        // Round-robin ties: last grant was TLB, so cache wins, then TLB.
        drive_c(1'b1, 1'b1, 32'h0000_2000, 3'b010);
        drive_t(1'b1, 32'h0000_4000);
        step();
        check("rr1_adr", r_adr, 32'h0000_2000);
        check("rr1_cti", {29'd0, r_cti}, 32'd2);
        check("fixed1_adr", adr, 32'h0000_4000);
        drive_c(1'b0, 1'b0, 32'h0, 3'b000);
        drive_t(1'b0, 32'h0);
        step();
        drive_c(1'b1, 1'b1, 32'h0000_2000, 3'b010);
        drive_t(1'b1, 32'h0000_4000);
        step();
        check("rr2_adr", r_adr, 32'h0000_4000);
        check("rr2_bte", {30'd0, r_bte}, 32'd0);
        drive_c(1'b0, 1'b0, 32'h0, 3'b000);
        drive_t(1'b0, 32'h0);
        step();

        // Single TLB walk.
        drive_t(1'b1, 32'h0000_4008);
        step();
        check("walk_adr", adr, 32'h0000_4008);
        check("walk_cti", {29'd0, cti}, 32'd7);
        ack = 1'b1;
        #1;
        check("walk_acks", {30'd0, c_ack, t_ack}, 32'd1);
        drive_t(1'b0, 32'h0);
        step();
        check("walk_end_acks", {30'd0, c_ack, t_ack}, 32'd0);
        check("walk_end_adr_hold", adr, 32'h0000_4008);

        // Stray ack while idle.
        step();
        check("stray_acks", {30'd0, c_ack, t_ack}, 32'd0);
        check("stray_cyc", {31'd0, cyc}, 32'd0);
        ack = 1'b0;

        // Cache burst with a TLB request arriving at beat 2 and one wait state.
        for (int b = 0; b < 4; b++) begin
            drive_c(1'b1, 1'b1, burst_adr[b], burst_cti[b]);
            if (b == 2) drive_t(1'b1, 32'h0000_4010);
            step();
            check("burst_adr", adr, burst_adr[b]);
            check("burst_cti", {29'd0, cti}, {29'd0, burst_cti[b]});
            check("burst_bte", {30'd0, bte}, 32'd1);
            ack = 1'b1;
            #1;
            check("burst_acks", {30'd0, c_ack, t_ack}, 32'd2);
            ack = 1'b0;
            if (b == 1) begin
                c_stb = 1'b0;
                step();
                check("wait_state_stb", {30'd0, cyc, stb}, 32'd2);
            end
        end
        drive_c(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        check("burst_drop_cyc", {31'd0, cyc}, 32'd0);
        check("burst_drop_adr_hold", adr, 32'h100C);
        step();
        check("tlb_after_burst_cyc", {31'd0, cyc}, 32'd1);
        check("tlb_after_burst_adr", adr, 32'h0000_4010);
        drive_t(1'b0, 32'h0);
        step();

        // Reset during beat 2 of a cache burst.
        for (int b = 0; b < 2; b++) begin
            drive_c(1'b1, 1'b1, burst_adr[b], burst_cti[b]);
            step();
        end
        drive_c(1'b1, 1'b1, burst_adr[2], burst_cti[2]);
        rst = 1'b1;
        ack = 1'b1;
        step();
        check("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        check("mid_rst_acks", {30'd0, c_ack, t_ack}, 32'd0);
        rst = 1'b0;
        ack = 1'b0;
        drive_c(1'b1, 1'b1, burst_adr[0], burst_cti[0]);
        step();
        check("rearb_cyc", {31'd0, cyc}, 32'd1);
        check("rearb_adr", adr, 32'h1000);
        drive_c(1'b0, 1'b0, 32'h0, 3'b000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
